// File: rtl/regbank_arbiter_if.sv
// Requester, response and register-bank signals shared by regbank_arbiter.
// slave = arbiter side, master = requesters plus bank model side.
interface regbank_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [5:0]  core_addr;
  logic [15:0] core_wdata;
  logic        core_ack;

  logic        dbg_req;
  logic        dbg_we;
  logic [5:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_ack;

  logic [15:0] rdata;
  logic        err;
  logic        busy;

  logic [5:0]  Sel_B;
  logic [15:0] Data_B;
  logic [5:0]  Sel_C;
  logic [15:0] Data_C;
  logic        C_WE;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  Data_B,
    output core_ack, dbg_ack, rdata, err, busy,
    output Sel_B, Sel_C, Data_C, C_WE
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output Data_B,
    input  core_ack, dbg_ack, rdata, err, busy,
    input  Sel_B, Sel_C, Data_C, C_WE
  );
endinterface

// File: rtl/regbank_arbiter.sv
// Two-requester arbiter/sequencer for the 16-bit register bank B/C ports.
// Define REGBANK_ARB_FIXED_PRIO_EN for fixed core priority; default is round-robin.
module regbank_arbiter (
  input  logic             clk,
  input  logic             nreset,
  regbank_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   grant_dbg;
  logic   cmd_we;
  logic   cmd_legal;

  logic        pick_dbg;
  logic        sel_we;
  logic [5:0]  sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_legal;

  function automatic logic read_ok(input logic [5:0] a);
    return (a <= 6'd31) || (a == 6'd34);
  endfunction

  // 28 and 29 are input ports, so they are readable but never writable.
  function automatic logic write_ok(input logic [5:0] a);
    return (a <= 6'd27) || (a == 6'd30) || (a == 6'd31) || (a == 6'd34);
  endfunction

`ifdef REGBANK_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_dbg = bus.dbg_req && !bus.core_req;
  end
`else
  logic last_grant;

  // last_grant == 1 means debug went last, so core takes the next tie.
  always_comb begin
    pick_dbg = bus.dbg_req && (!bus.core_req || !last_grant);
  end
`endif

  always_comb begin
    sel_we    = pick_dbg ? bus.dbg_we    : bus.core_we;
    sel_addr  = pick_dbg ? bus.dbg_addr  : bus.core_addr;
    sel_wdata = pick_dbg ? bus.dbg_wdata : bus.core_wdata;
    sel_legal = sel_we ? write_ok(sel_addr) : read_ok(sel_addr);
  end

  // Bank-side registers are loaded on the grant edge so they are valid throughout ACCESS.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      grant_dbg  <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_legal  <= 1'b0;
`ifndef REGBANK_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
      bus.Sel_B    <= '0;
      bus.Sel_C    <= '0;
      bus.Data_C   <= '0;
      bus.C_WE     <= 1'b0;
      bus.core_ack <= 1'b0;
      bus.dbg_ack  <= 1'b0;
      bus.rdata    <= '0;
      bus.err      <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.core_ack <= 1'b0;
          bus.dbg_ack  <= 1'b0;
          bus.err      <= 1'b0;
          if (bus.core_req || bus.dbg_req) begin
            grant_dbg  <= pick_dbg;
            cmd_we     <= sel_we;
            cmd_legal  <= sel_legal;
            bus.Sel_B  <= sel_addr;
            bus.Sel_C  <= sel_addr;
            bus.Data_C <= sel_wdata;
            bus.C_WE   <= sel_we && sel_legal;
            bus.busy   <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          bus.C_WE <= 1'b0;
          if (!cmd_we && cmd_legal) begin
            bus.rdata <= bus.Data_B;
          end
          bus.core_ack <= !grant_dbg;
          bus.dbg_ack  <= grant_dbg;
          bus.err      <= !cmd_legal;
          state        <= RESP;
        end
        RESP: begin
          bus.core_ack <= 1'b0;
          bus.dbg_ack  <= 1'b0;
          bus.err      <= 1'b0;
          bus.busy     <= 1'b0;
`ifndef REGBANK_ARB_FIXED_PRIO_EN
          last_grant   <= grant_dbg;
`endif
          state        <= IDLE;
        end
        default: begin
          bus.C_WE     <= 1'b0;
          bus.core_ack <= 1'b0;
          bus.dbg_ack  <= 1'b0;
          bus.err      <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  a_we_only_in_access: assert property (@(posedge clk) disable iff (!nreset)
    bus.C_WE |-> (state == ACCESS));

  a_single_ack: assert property (@(posedge clk) disable iff (!nreset)
    !(bus.core_ack && bus.dbg_ack));

  a_busy_tracks_state: assert property (@(posedge clk) disable iff (!nreset)
    bus.busy == (state != IDLE));

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed self-checking bench for regbank_arbiter with a 64-entry bank model.
// Honors REGBANK_ARB_FIXED_PRIO_EN when computing expected grant order.
module tb_regbank_arbiter;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic bank_init = 1'b1;

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  regbank_arbiter_if bus();

  regbank_arbiter dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  function automatic logic [15:0] bank_default(input int i);
    return (i == 28) ? 16'h1234 : 16'(i * 257);
  endfunction

  // Bank model: combinational read, write on the rising edge when strobed.
  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= bank_default(i);
    end else if (bus.C_WE) begin
      mem[bus.Sel_C] <= bus.Data_C;
    end
  end
  assign bus.Data_B = mem[bus.Sel_B];

  typedef struct {
    string       name;
    logic        dbg;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic        expErr;
    logic [15:0] expRdata;
    int          expCwe;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [63:0] allOutputs();
    return {15'd0, bus.Sel_B, bus.Sel_C, bus.Data_C, bus.C_WE, bus.core_ack,
            bus.dbg_ack, bus.rdata, bus.err, bus.busy};
  endfunction

  // Runs one transaction from an IDLE negedge and returns what was observed.
  task automatic applyStimulus(input logic dbg, input logic we, input logic [5:0] addr,
                               input logic [15:0] wdata, output int latency,
                               output logic wrongAck, output int cweCount,
                               output logic [5:0] selBAcc, output logic [5:0] selCAcc,
                               output logic [15:0] dataCAcc, output logic errAck,
                               output logic [15:0] rdataAck);
    latency = -1; wrongAck = 1'b0; cweCount = 0;
    selBAcc = '0; selCAcc = '0; dataCAcc = '0; errAck = 1'b0; rdataAck = '0;
    if (dbg) begin
      bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    end else begin
      bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wdata;
    end
    for (int k = 1; k <= 10 && latency < 0; k++) begin
      @(negedge clk);
      if (bus.C_WE) cweCount++;
      if (k == 1) begin
        selBAcc = bus.Sel_B; selCAcc = bus.Sel_C; dataCAcc = bus.Data_C;
      end
      if (dbg ? bus.core_ack : bus.dbg_ack) wrongAck = 1'b1;
      if (dbg ? bus.dbg_ack : bus.core_ack) begin
        latency = k; errAck = bus.err; rdataAck = bus.rdata;
      end
    end
    bus.core_req = 1'b0;
    bus.dbg_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int latency, cweCount, nAck, count, acks;
    logic wrongAck, errAck, expDbg, extraAck;
    logic [5:0] selBAcc, selCAcc;
    logic [15:0] dataCAcc, rdataAck;
    int ackCycle[6];
    logic ackDbg[6];
    logic [15:0] ackData[6];

    vecs[0]  = '{"core wr 5",    1'b0, 1'b1, 6'd5,  16'hBEEF, 1'b0, 16'h0000, 1};
    vecs[1]  = '{"dbg rd 28",    1'b1, 1'b0, 6'd28, 16'h0000, 1'b0, 16'h1234, 0};
    vecs[2]  = '{"dbg wr 29",    1'b1, 1'b1, 6'd29, 16'hAAAA, 1'b1, 16'h1234, 0};
    vecs[3]  = '{"core rd 40",   1'b0, 1'b0, 6'd40, 16'h0000, 1'b1, 16'h1234, 0};
    vecs[4]  = '{"dbg wr 31",    1'b1, 1'b1, 6'd31, 16'h5555, 1'b0, 16'h1234, 1};
    vecs[5]  = '{"core rd 31",   1'b0, 1'b0, 6'd31, 16'h0000, 1'b0, 16'h5555, 0};
    vecs[6]  = '{"dbg rd 34",    1'b1, 1'b0, 6'd34, 16'h0000, 1'b0, 16'h2222, 0};
    vecs[7]  = '{"core wr 32",   1'b0, 1'b1, 6'd32, 16'h7777, 1'b1, 16'h2222, 0};
    vecs[8]  = '{"dbg rd 63",    1'b1, 1'b0, 6'd63, 16'h0000, 1'b1, 16'h2222, 0};
    vecs[9]  = '{"core wr 28",   1'b0, 1'b1, 6'd28, 16'h9999, 1'b1, 16'h2222, 0};
    vecs[10] = '{"core rd 5",    1'b0, 1'b0, 6'd5,  16'h0000, 1'b0, 16'hBEEF, 0};
    vecs[11] = '{"dbg wr 0",     1'b1, 1'b1, 6'd0,  16'h0001, 1'b0, 16'hBEEF, 1};
    vecs[12] = '{"dbg rd 32",    1'b1, 1'b0, 6'd32, 16'h0000, 1'b1, 16'hBEEF, 0};
    vecs[13] = '{"core rd 29",   1'b0, 1'b0, 6'd29, 16'h0000, 1'b0, 16'h1D1D, 0};

    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;

    repeat (3) @(negedge clk);
    checkOutput("outputs in reset", allOutputs(), 64'd0);
    nreset = 1'b1;
    bank_init = 1'b0;
    @(negedge clk);
    checkOutput("outputs after reset", allOutputs(), 64'd0);

    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].dbg, vecs[v].we, vecs[v].addr, vecs[v].wdata, latency, wrongAck,
                    cweCount, selBAcc, selCAcc, dataCAcc, errAck, rdataAck);
      checkOutput({vecs[v].name, " ack latency"}, 64'(latency), 64'd2);
      checkOutput({vecs[v].name, " wrong ack"}, 64'(wrongAck), 64'd0);
      checkOutput({vecs[v].name, " C_WE cycles"}, 64'(cweCount), 64'(vecs[v].expCwe));
      checkOutput({vecs[v].name, " Sel_B"}, 64'(selBAcc), 64'(vecs[v].addr));
      checkOutput({vecs[v].name, " Sel_C"}, 64'(selCAcc), 64'(vecs[v].addr));
      checkOutput({vecs[v].name, " Data_C"}, 64'(dataCAcc), 64'(vecs[v].wdata));
      checkOutput({vecs[v].name, " err"}, 64'(errAck), 64'(vecs[v].expErr));
      checkOutput({vecs[v].name, " rdata"}, 64'(rdataAck), 64'(vecs[v].expRdata));
      checkOutput({vecs[v].name, " busy after"}, 64'(bus.busy), 64'd0);
    end

    // Both requesters held high: grant order and 3-cycle ack spacing.
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    nAck = 0;
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 6'd1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 6'd2;
    for (int k = 1; k <= 40 && nAck < 6; k++) begin
      @(negedge clk);
      if (bus.core_ack || bus.dbg_ack) begin
        ackCycle[nAck] = k; ackDbg[nAck] = bus.dbg_ack; ackData[nAck] = bus.rdata;
        nAck++;
      end
    end
    bus.core_req = 1'b0;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    checkOutput("tie ack count", 64'(nAck), 64'd6);
    for (int i = 0; i < nAck; i++) begin
`ifdef REGBANK_ARB_FIXED_PRIO_EN
      expDbg = 1'b0;
`else
      expDbg = (i % 2) == 1;
`endif
      checkOutput($sformatf("tie grant %0d is dbg", i), 64'(ackDbg[i]), 64'(expDbg));
      checkOutput($sformatf("tie rdata %0d", i), 64'(ackData[i]), expDbg ? 64'h0202 : 64'h0101);
      if (i > 0) checkOutput($sformatf("tie spacing %0d", i), 64'(ackCycle[i] - ackCycle[i-1]), 64'd3);
    end

    // Reset during ACCESS: strobe drops asynchronously, no ack, write lost.
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 6'd34; bus.core_wdata = 16'h00FF;
    @(negedge clk);
    checkOutput("abort C_WE in ACCESS", 64'(bus.C_WE), 64'd1);
    #2;
    nreset = 1'b0;
    bus.core_req = 1'b0;
    #1;
    checkOutput("abort C_WE async low", 64'(bus.C_WE), 64'd0);
    extraAck = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.core_ack || bus.dbg_ack) extraAck = 1'b1;
    end
    nreset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.core_ack || bus.dbg_ack) extraAck = 1'b1;
    end
    checkOutput("abort no ack", 64'(extraAck), 64'd0);
    checkOutput("abort outputs zero", allOutputs(), 64'd0);
    checkOutput("abort bank 34 untouched", 64'(mem[34]), 64'h2222);

    // Write then read-back of address 30 with core req held across both.
    count = 1; acks = 0; cweCount = 0; errAck = 1'b1; rdataAck = '0;
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 6'd30; bus.core_wdata = 16'hA5A5;
    for (int k = 0; k < 20 && acks < 2; k++) begin
      @(negedge clk);
      count++;
      if (bus.C_WE) cweCount++;
      if (bus.core_ack) begin
        acks++;
        bus.core_we = 1'b0;
        if (acks == 2) begin
          errAck = bus.err; rdataAck = bus.rdata;
        end
      end
    end
    bus.core_req = 1'b0;
    @(negedge clk);
    checkOutput("echo acks", 64'(acks), 64'd2);
    checkOutput("echo total cycles", 64'(count), 64'd6);
    checkOutput("echo C_WE cycles", 64'(cweCount), 64'd1);
    checkOutput("echo rdata", 64'(rdataAck), 64'hA5A5);
    checkOutput("echo err", 64'(errAck), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
# regbank_arbiter

Two-requester access arbiter and sequencer for the 16-bit register bank. It shares the bank's B read port and C write port between the core writeback path (requester 0) and the debug/host access path (requester 1). Each granted transaction runs through a fixed three-state sequence: grant, bank access, response. Illegal accesses are rejected without touching the bank.

## Interface
- No parameters. Data width is 16 and select width is 6, both fixed by the bank.
- `clk` input 1: clock; all state updates on the rising edge.
- `nreset` input 1: asynchronous, active-low reset.
- `core_req` input 1: requester 0 request. Held high until `core_ack`.
- `core_we` input 1: requester 0 direction (1 = write, 0 = read). Stable while `core_req` is high.
- `core_addr` input 6: requester 0 bank select. Stable while `core_req` is high.
- `core_wdata` input 16: requester 0 write data. Stable while `core_req` is high.
- `core_ack` output 1: one-cycle completion pulse for requester 0.
- `dbg_req`, `dbg_we`, `dbg_addr`[6], `dbg_wdata`[16], `dbg_ack`: requester 1 equivalents with identical rules.
- `rdata` output 16: read result. Valid in the ack cycle; holds its value until the next read completes.
- `err` output 1: illegal-access flag, valid in the ack cycle.
- `Sel_B` output 6: bank read select.
- `Data_B` input 16: bank read data. Combinational from `Sel_B`.
- `Sel_C` output 6: bank write select.
- `Data_C` output 16: bank write data.
- `C_WE` output 1: bank write strobe, at most one cycle per transaction.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- Legal read addresses: 0–31 and 34.
- Legal write addresses: 0–27, 30, 31 and 34. Addresses 28 and 29 are input ports and are read-only.
- Every other address is illegal for both reads and writes.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If either request is high, pick a winner and latch its `we`, `addr` and `wdata` into the command register and the grant index, then go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration is round-robin:
  - A single requester wins outright.
  - When both request, the one not granted last wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- ACCESS:
  - `Sel_B` = `Sel_C` = latched address; `Data_C` = latched wdata.
  - Legal write: `C_WE` = 1 for this cycle only.
  - Read: capture `Data_B` into `rdata` on the closing edge. Illegal reads leave `rdata` unchanged.
  - Always go to RESP.
- RESP:
  - Pulse the winner's ack for one cycle; `err` = 1 if the access was illegal.
  - Update `last_grant`, then go to IDLE.
- Requesters drop `req` on the edge that ends their ack cycle. A `req` still high in IDLE is treated as a new transaction.
- `Sel_B`, `Sel_C` and `Data_C` hold their last value outside ACCESS. `C_WE` is 0 outside ACCESS.

## Timing
- Reset values: FSM = IDLE, `last_grant` = 1.
- All outputs reset to 0: `Sel_B`, `Sel_C`, `Data_C`, `C_WE`, `core_ack`, `dbg_ack`, `rdata`, `err`, `busy`.
- All outputs are registered.
- Latency from a request seen in IDLE at edge N:
  - ACCESS occupies cycle N+1; `C_WE` is high in that cycle.
  - Ack, `err` and `rdata` are valid in cycle N+2.
  - The next grant can be made at the edge that ends cycle N+3.
  - Throughput is one transaction per 3 cycles.
- A request arriving mid-transaction waits and is never dropped.
- With both requesters continuously requesting, grants strictly alternate.
- Reset mid-transaction aborts it: no strobe, no ack.
- Reset asserted during ACCESS forces `C_WE` low immediately (asynchronous). A write may be lost; this is acceptable.

## Configuration
- `REGBANK_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. Requester 0 (core) always wins a tie and `last_grant` is unused; requester 1 can starve.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset with both requests low:
  - All outputs 0.
  - `core_req` write addr 5, data 0xBEEF → `C_WE` = 1 with `Sel_C` = 5 and `Data_C` = 0xBEEF in cycle N+1.
  - `core_ack` in N+2 with `err` = 0.
- Debug read addr 28 with bank model `Data_B` = 0x1234:
  - `Sel_B` = 28 in ACCESS.
  - `dbg_ack` with `rdata` = 0x1234 and `err` = 0.
- Debug write addr 29, then core read addr 40:
  - Each gives ack with `err` = 1.
  - `C_WE` never asserts.
  - `rdata` keeps its previous value.
- Both requests held continuously for 6 transactions:
  - Grant order core, dbg, core, dbg, core, dbg.
  - Acks spaced 3 cycles apart.
  - With `REGBANK_ARB_FIXED_PRIO_EN` defined, all 6 grants go to core.
- Core write addr 34, data 0x00FF: `nreset` pulsed low during ACCESS →
  - `C_WE` falls asynchronously.
  - No ack.
  - FSM returns to IDLE and all outputs are 0.
- Core write addr 30, data 0xA5A5, then core read addr 30 with the bank model echoing the write:
  - Read returns `rdata` = 0xA5A5.
  - Total 6 cycles from first grant to second ack.
